kitchen_feedback_monitor: RTL and testbench
===========================================

# kitchen_feedback_monitor

Receive-side companion to the manual/automatic command drivers. It samples the 8-bit feedback word `out_bits` that the Genshin Kitchen client returns, and synchronizes and glitch-filters its status fields. It tracks each operate command seen on `in_bits` through acknowledge and completion, and reports done, timeout or abort to the controller and the LEDs. It sits between the client UART bridge and the command FSMs.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical synchronized samples required before a filtered field updates (>=1).
- `ACK_TIMEOUT`, default 1000: cycles allowed in WAIT_ACK.
- `DONE_TIMEOUT`, default 100000: cycles allowed in WAIT_DONE.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_bits`  in  8  command word currently driven to the client; same clock domain.
- `out_bits`  in  8  feedback word from the client; asynchronous. Fields:
  - [2] ready (player idle)
  - [3] near_target
  - [4] holding
  - [5] machine_ready
  - [7:6] and [1:0] ignored
- `fb_status`  out  4  filtered {machine_ready, holding, near_target, ready}.
- `holding_rise` / `holding_fall`  out  1 each  one-cycle pulse on a filtered holding edge.
- `machine_done`  out  1  one-cycle pulse on a filtered machine_ready 0->1 edge.
- `cmd_busy`  out  1  high while the tracker is in WAIT_ACK or WAIT_DONE.
- `cmd_done` / `cmd_timeout` / `cmd_abort`  out  1 each  one-cycle result pulses.
- `last_op`  out  3  code of the last accepted command: 1 get, 2 put, 3 interact, 4 move, 5 throw, 0 none.
- `done_count`  out  8  completed-command counter; wraps 255->0.
- `state_dbg`  out  2  tracker state: 0 IDLE, 1 WAIT_ACK, 2 WAIT_DONE.

## Operation
- **Synchronizer:** `out_bits[5:2]` passes through a 2-flop synchronizer.
- **Filter:** each bit has its own run counter. The filtered bit takes the synchronized value after STABLE_CYCLES consecutive equal samples that differ from the current filtered value. Any mismatch restarts the count.
- **Edge pulses:** derived from filtered bits only, registered.
- **`in_bits` history:** `prev_in` registers `in_bits` every cycle.
- **Issue event:** `in_bits[1:0]==2'b10`, `in_bits[6:2]` exactly one-hot, `in_bits[7]==0`, and `in_bits != prev_in`. Non-one-hot operate words are ignored.
- **Abort event:** `in_bits==8'b0000_1001` (game stop) while `cmd_busy`.
- **Tracker FSM:**
  - IDLE: on issue, latch `last_op`, clear the timer, go to WAIT_ACK.
  - WAIT_ACK:
    - filtered ready==0: clear the timer, go to WAIT_DONE.
    - else timer==ACK_TIMEOUT-1: `cmd_timeout`, go to IDLE.
    - else increment the timer.
  - WAIT_DONE:
    - filtered ready==1: `cmd_done`, `done_count`+1, go to IDLE.
    - else timer==DONE_TIMEOUT-1: `cmd_timeout`, go to IDLE.
    - else increment the timer.
  - Abort from any busy state: `cmd_abort`, go to IDLE. Abort has priority over ack, done and timeout in the same cycle.
  - An issue event while busy is ignored; `last_op` is unchanged.
- **Select/start commands** (`in_bits[1:0]` 11 or 01, other than stop-while-busy) do not affect the tracker.
- **Timer width:** `$clog2(max(ACK_TIMEOUT, DONE_TIMEOUT))` bits; it never wraps.

## Timing
- **Reset:** all outputs, filtered bits, counters, `prev_in`, and the FSM (IDLE) are 0.
- **Filter latency:** a change on `out_bits` held steady appears on `fb_status` exactly 2+STABLE_CYCLES cycles later. Edge pulses are asserted in the same cycle `fb_status` changes.
- **Issue:** in_bits changes in cycle N → `cmd_busy`=1 and `last_op` valid from N+1.
- **Results:**
  - `cmd_done`, `cmd_timeout` and `cmd_abort` are high for exactly the first IDLE cycle.
  - `cmd_busy` is 0 in that cycle.
  - `done_count` shows the new value in that cycle.
- **Timeout:** exactly ACK_TIMEOUT (DONE_TIMEOUT) cycles after entering the state with no ack (done), the next cycle is IDLE with the pulse.
- **Back-to-back:** a new issue in the pulse cycle is accepted, and `cmd_busy` rises the following cycle.
- **Mid-operation reset:** forces IDLE immediately, with no result pulse.

## Test plan
Bench parameters: STABLE_CYCLES=2, ACK_TIMEOUT=8, DONE_TIMEOUT=16.

1. **Filter:** `out_bits[4]` toggles 1 cycle high → `fb_status` unchanged, no pulse. Held high 5 cycles → `fb_status[2]`=1 at +4 cycles with `holding_rise` for 1 cycle.
2. **Normal command:**
   - `in_bits`=0x06 (get) → `cmd_busy`=1, `last_op`=1.
   - `out_bits[2]` drops, then rises → `cmd_done` pulse, `done_count`=1, `cmd_busy`=0.
3. **Ack timeout:** `in_bits`=0x22 (move) with ready held 1 → `cmd_timeout` exactly 8 cycles after WAIT_ACK entry, `done_count` unchanged.
4. **Abort and busy-ignore:**
   - 0x12 (interact), ready dropped → WAIT_DONE.
   - Apply 0x0A → ignored, `last_op` stays 3.
   - Apply 0x09 → `cmd_abort` pulse, IDLE, no `cmd_done`.
5. **Illegal and wrap:**
   - `in_bits`=0x0E (two ops) → stays IDLE.
   - 256 completed gets → `done_count` returns to 0.
6. **Reset mid-operation:** assert `rst` in WAIT_DONE → all outputs 0 asynchronously; after release the tracker is IDLE with no pulses.

Source files
------------

// File: rtl/kitchen_feedback_if.sv
// kitchen_feedback_if
// Bundles the command/feedback words and the monitor's status outputs so the
// command FSMs, the LED block and the monitor share a single connection.
//   in_bits      : command word driven to the client (synchronous to clk)
//   out_bits     : raw feedback word from the client (asynchronous)
//   fb_status    : filtered {machine_ready, holding, near_target, ready}
//   holding_rise/holding_fall/machine_done : one-cycle filtered-edge pulses
//   cmd_busy     : tracker is waiting for acknowledge or completion
//   cmd_done/cmd_timeout/cmd_abort : one-cycle command result pulses
//   last_op      : code of the last accepted operate command
//   done_count   : completed-command counter (wraps)
//   state_dbg    : tracker state (0 IDLE, 1 WAIT_ACK, 2 WAIT_DONE)
// master drives the command/feedback words; slave is the monitor.
interface kitchen_feedback_if;
  logic [7:0] in_bits;
  logic [7:0] out_bits;
  logic [3:0] fb_status;
  logic       holding_rise;
  logic       holding_fall;
  logic       machine_done;
  logic       cmd_busy;
  logic       cmd_done;
  logic       cmd_timeout;
  logic       cmd_abort;
  logic [2:0] last_op;
  logic [7:0] done_count;
  logic [1:0] state_dbg;

  modport master (
    output in_bits, out_bits,
    input  fb_status, holding_rise, holding_fall, machine_done,
    input  cmd_busy, cmd_done, cmd_timeout, cmd_abort,
    input  last_op, done_count, state_dbg
  );

  modport slave (
    input  in_bits, out_bits,
    output fb_status, holding_rise, holding_fall, machine_done,
    output cmd_busy, cmd_done, cmd_timeout, cmd_abort,
    output last_op, done_count, state_dbg
  );
endinterface

// File: rtl/kitchen_feedback_monitor.sv
// kitchen_feedback_monitor
// Samples the client's feedback word, synchronizes and glitch-filters the
// status fields out_bits[5:2], and tracks each operate command seen on
// in_bits through acknowledge (ready falls) and completion (ready rises),
// reporting done, timeout or abort.
// Ports:
//   clk  : system clock, all state on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : kitchen_feedback_if.slave (command/feedback words and all status)
module kitchen_feedback_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int ACK_TIMEOUT   = 1000,
  parameter int DONE_TIMEOUT  = 100000
) (
  input logic              clk,
  input logic              rst,
  kitchen_feedback_if.slave bus
);

  localparam int TMR_MAX = (ACK_TIMEOUT > DONE_TIMEOUT) ? ACK_TIMEOUT : DONE_TIMEOUT;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] ACK_LAST  = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] DONE_LAST = TMR_W'(DONE_TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_ACK  = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  localparam logic [7:0] STOP_WORD = 8'b0000_1001;

  // Bits 7:6 and 1:0 of the feedback word carry nothing for this block.
  logic unused_fb_bits;
  assign unused_fb_bits = ^{bus.out_bits[7:6], bus.out_bits[1:0]};

  // ---- stage p0/p1: two-flop synchronizer for the asynchronous feedback
  logic [3:0] sync_p0;
  logic [3:0] sync_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= bus.out_bits[5:2];
      sync_p1 <= sync_p0;
    end
  end

  // ---- stage p2: per-bit run-length glitch filter and edge pulses
  logic [3:0]            filt_p2;
  logic [3:0][CNT_W-1:0] run_cnt_p2;
  logic [3:0]            upd;
  logic                  holding_rise_p2;
  logic                  holding_fall_p2;
  logic                  machine_done_p2;

  // A bit updates on the STABLE_CYCLES-th consecutive sample that disagrees
  // with the filtered value; the counter only ever counts disagreeing samples.
  always_comb begin
    upd = '0;
    for (int i = 0; i < 4; i++) begin
      upd[i] = (sync_p1[i] != filt_p2[i]) && (run_cnt_p2[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_p2         <= '0;
      run_cnt_p2      <= '0;
      holding_rise_p2 <= 1'b0;
      holding_fall_p2 <= 1'b0;
      machine_done_p2 <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] == filt_p2[i]) begin
          run_cnt_p2[i] <= '0;
        end else if (upd[i]) begin
          run_cnt_p2[i] <= '0;
          filt_p2[i]    <= sync_p1[i];
        end else begin
          run_cnt_p2[i] <= run_cnt_p2[i] + 1'b1;
        end
      end
      // Pulses share the update edge so they line up with fb_status.
      holding_rise_p2 <= upd[2] &  sync_p1[2];
      holding_fall_p2 <= upd[2] & ~sync_p1[2];
      machine_done_p2 <= upd[3] &  sync_p1[3];
    end
  end

  logic ready_f;
  assign ready_f = filt_p2[0];

  // ---- command decode (in_bits is already in the clk domain)
  logic [7:0] prev_in;
  logic [4:0] op_sel;
  logic [2:0] op_code;
  logic       issue;
  logic       abort;
  logic [1:0] state;
  logic       busy;

  assign op_sel = bus.in_bits[6:2];
  assign busy   = (state != ST_IDLE);

  // Edge-detect on the word so a command held on the bus issues only once.
  assign issue = (bus.in_bits[1:0] == 2'b10) && $onehot(op_sel) &&
                 !bus.in_bits[7] && (bus.in_bits != prev_in);
  assign abort = (bus.in_bits == STOP_WORD) && busy;

  always_comb begin
    op_code = 3'd0;
    case (op_sel)
      5'b00001: op_code = 3'd1;
      5'b00010: op_code = 3'd2;
      5'b00100: op_code = 3'd3;
      5'b01000: op_code = 3'd4;
      5'b10000: op_code = 3'd5;
      default:  op_code = 3'd0;
    endcase
  end

  // ---- tracker FSM; result pulses are registered into the first IDLE cycle
  logic [TMR_W-1:0] tmr;
  logic [2:0]       last_op;
  logic [7:0]       done_count;
  logic             cmd_done;
  logic             cmd_timeout;
  logic             cmd_abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_in     <= '0;
      state       <= ST_IDLE;
      tmr         <= '0;
      last_op     <= '0;
      done_count  <= '0;
      cmd_done    <= 1'b0;
      cmd_timeout <= 1'b0;
      cmd_abort   <= 1'b0;
    end else begin
      prev_in     <= bus.in_bits;
      cmd_done    <= 1'b0;
      cmd_timeout <= 1'b0;
      cmd_abort   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            last_op <= op_code;
            tmr     <= '0;
            state   <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (abort) begin
            cmd_abort <= 1'b1;
            state     <= ST_IDLE;
          end else if (!ready_f) begin
            tmr   <= '0;
            state <= ST_WAIT_DONE;
          end else if (tmr == ACK_LAST) begin
            cmd_timeout <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (abort) begin
            cmd_abort <= 1'b1;
            state     <= ST_IDLE;
          end else if (ready_f) begin
            cmd_done   <= 1'b1;
            done_count <= done_count + 1'b1;
            state      <= ST_IDLE;
          end else if (tmr == DONE_LAST) begin
            cmd_timeout <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.fb_status    = filt_p2;
  assign bus.holding_rise = holding_rise_p2;
  assign bus.holding_fall = holding_fall_p2;
  assign bus.machine_done = machine_done_p2;
  assign bus.cmd_busy     = busy;
  assign bus.cmd_done     = cmd_done;
  assign bus.cmd_timeout  = cmd_timeout;
  assign bus.cmd_abort    = cmd_abort;
  assign bus.last_op      = last_op;
  assign bus.done_count   = done_count;
  assign bus.state_dbg    = state;

endmodule

// File: tb/tb_kitchen_feedback_monitor.sv
// tb_kitchen_feedback_monitor
// Directed bench for kitchen_feedback_monitor with STABLE_CYCLES=2,
// ACK_TIMEOUT=8, DONE_TIMEOUT=16. Inputs change and outputs are sampled
// 1 time unit after each rising clock edge.
module tb_kitchen_feedback_monitor;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  kitchen_feedback_if fb_if ();

  kitchen_feedback_monitor #(
    .STABLE_CYCLES(2),
    .ACK_TIMEOUT  (8),
    .DONE_TIMEOUT (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(fb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One complete get: issue with ready dropping, then ready returns.
  task automatic do_get();
    fb_if.in_bits  = 8'h06;
    fb_if.out_bits = 8'h00;
    tick();
    fb_if.in_bits = 8'h00;
    tick(5);
    fb_if.out_bits = 8'h04;
    tick(5);
  endtask

  logic pulse_seen;

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b0;
    fb_if.in_bits  = 8'h00;
    fb_if.out_bits = 8'h00;
    #2 rst = 1'b1;
    tick(2);

    // Reset state
    chk("rst_fb",    32'(fb_if.fb_status), 32'h0);
    chk("rst_busy",  32'(fb_if.cmd_busy), 32'h0);
    chk("rst_state", 32'(fb_if.state_dbg), 32'h0);
    chk("rst_cnt",   32'(fb_if.done_count), 32'h0);
    chk("rst_op",    32'(fb_if.last_op), 32'h0);
    rst = 1'b0;

    // Ready filter latency: 2 sync + 2 stable cycles
    fb_if.out_bits = 8'h04;
    tick(3);
    chk("ready_lat3", 32'(fb_if.fb_status), 32'h0);
    tick();
    chk("ready_lat4", 32'(fb_if.fb_status), 32'h1);

    // 1. Filter: one-cycle glitch on holding is rejected
    fb_if.out_bits = 8'h14;
    tick();
    fb_if.out_bits = 8'h04;
    pulse_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      pulse_seen = pulse_seen | fb_if.holding_rise | fb_if.holding_fall;
    end
    chk("glitch_fb", 32'(fb_if.fb_status), 32'h1);
    chk("glitch_pulse", 32'(pulse_seen), 32'h0);

    // Held holding appears after 4 cycles with a single rise pulse
    fb_if.out_bits = 8'h14;
    tick(3);
    chk("hold_fb3", 32'(fb_if.fb_status), 32'h1);
    chk("hold_rise3", 32'(fb_if.holding_rise), 32'h0);
    tick();
    chk("hold_fb4", 32'(fb_if.fb_status), 32'h5);
    chk("hold_rise4", 32'(fb_if.holding_rise), 32'h1);
    tick();
    chk("hold_rise5", 32'(fb_if.holding_rise), 32'h0);
    fb_if.out_bits = 8'h04;
    tick(4);
    chk("hold_fall", 32'(fb_if.holding_fall), 32'h1);
    chk("hold_fb_off", 32'(fb_if.fb_status), 32'h1);

    // machine_ready rising edge pulse
    fb_if.out_bits = 8'h24;
    tick(4);
    chk("mach_done", 32'(fb_if.machine_done), 32'h1);
    chk("mach_fb", 32'(fb_if.fb_status), 32'h9);
    tick();
    chk("mach_done_1cyc", 32'(fb_if.machine_done), 32'h0);
    fb_if.out_bits = 8'h04;
    tick(5);

    // 2. Normal command: get
    fb_if.in_bits = 8'h06;
    tick();
    chk("get_busy", 32'(fb_if.cmd_busy), 32'h1);
    chk("get_op", 32'(fb_if.last_op), 32'h1);
    chk("get_state_ack", 32'(fb_if.state_dbg), 32'h1);
    fb_if.in_bits  = 8'h00;
    fb_if.out_bits = 8'h00;
    tick(4);
    chk("get_still_ack", 32'(fb_if.state_dbg), 32'h1);
    tick();
    chk("get_state_done", 32'(fb_if.state_dbg), 32'h2);
    fb_if.out_bits = 8'h04;
    tick(4);
    chk("get_done_early", 32'(fb_if.cmd_done), 32'h0);
    tick();
    chk("get_done", 32'(fb_if.cmd_done), 32'h1);
    chk("get_count", 32'(fb_if.done_count), 32'h1);
    chk("get_busy_off", 32'(fb_if.cmd_busy), 32'h0);
    chk("get_idle", 32'(fb_if.state_dbg), 32'h0);
    tick();
    chk("get_done_1cyc", 32'(fb_if.cmd_done), 32'h0);

    // 3. Ack timeout: move with ready held high
    fb_if.in_bits = 8'h22;
    tick();
    chk("move_op", 32'(fb_if.last_op), 32'h4);
    fb_if.in_bits = 8'h00;
    tick(7);
    chk("ackto_early", 32'(fb_if.cmd_timeout), 32'h0);
    chk("ackto_busy_early", 32'(fb_if.cmd_busy), 32'h1);
    tick();
    chk("ackto_pulse", 32'(fb_if.cmd_timeout), 32'h1);
    chk("ackto_busy", 32'(fb_if.cmd_busy), 32'h0);
    chk("ackto_count", 32'(fb_if.done_count), 32'h1);
    tick();
    chk("ackto_1cyc", 32'(fb_if.cmd_timeout), 32'h0);

    // Done timeout: put acknowledged but never completed
    fb_if.in_bits  = 8'h0A;
    fb_if.out_bits = 8'h00;
    tick();
    chk("put_op", 32'(fb_if.last_op), 32'h2);
    fb_if.in_bits = 8'h00;
    tick(4);
    chk("put_wait_done", 32'(fb_if.state_dbg), 32'h2);
    tick(15);
    chk("doneto_early", 32'(fb_if.cmd_timeout), 32'h0);
    tick();
    chk("doneto_pulse", 32'(fb_if.cmd_timeout), 32'h1);
    chk("doneto_idle", 32'(fb_if.state_dbg), 32'h0);
    chk("doneto_count", 32'(fb_if.done_count), 32'h1);
    fb_if.out_bits = 8'h04;
    tick(6);

    // 4. Abort and busy-ignore
    fb_if.in_bits  = 8'h12;
    fb_if.out_bits = 8'h00;
    tick();
    chk("int_op", 32'(fb_if.last_op), 32'h3);
    fb_if.in_bits = 8'h00;
    tick(5);
    chk("int_wait_done", 32'(fb_if.state_dbg), 32'h2);
    fb_if.in_bits = 8'h0A;
    tick();
    chk("busy_ignore_op", 32'(fb_if.last_op), 32'h3);
    chk("busy_ignore_state", 32'(fb_if.state_dbg), 32'h2);
    fb_if.in_bits = 8'h09;
    tick();
    chk("abort_pulse", 32'(fb_if.cmd_abort), 32'h1);
    chk("abort_idle", 32'(fb_if.state_dbg), 32'h0);
    chk("abort_no_done", 32'(fb_if.cmd_done), 32'h0);
    chk("abort_busy", 32'(fb_if.cmd_busy), 32'h0);
    fb_if.in_bits  = 8'h00;
    fb_if.out_bits = 8'h04;
    tick();
    chk("abort_1cyc", 32'(fb_if.cmd_abort), 32'h0);
    tick(5);

    // 5. Illegal two-op word is ignored
    fb_if.in_bits = 8'h0E;
    tick();
    chk("illegal_state", 32'(fb_if.state_dbg), 32'h0);
    chk("illegal_op", 32'(fb_if.last_op), 32'h3);
    fb_if.in_bits = 8'h00;
    tick();

    // Counter wrap: count is 1, 255 more gets bring it to 0
    for (int g = 0; g < 255; g++) do_get();
    chk("wrap_zero", 32'(fb_if.done_count), 32'h0);
    do_get();
    chk("wrap_one", 32'(fb_if.done_count), 32'h1);
    chk("wrap_op", 32'(fb_if.last_op), 32'h1);

    // 6. Reset mid-operation
    fb_if.in_bits  = 8'h06;
    fb_if.out_bits = 8'h00;
    tick();
    fb_if.in_bits = 8'h00;
    tick(5);
    chk("mid_wait_done", 32'(fb_if.state_dbg), 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(fb_if.cmd_busy), 32'h0);
    chk("mid_rst_state", 32'(fb_if.state_dbg), 32'h0);
    chk("mid_rst_op", 32'(fb_if.last_op), 32'h0);
    chk("mid_rst_cnt", 32'(fb_if.done_count), 32'h0);
    chk("mid_rst_fb", 32'(fb_if.fb_status), 32'h0);
    tick();
    rst = 1'b0;
    fb_if.out_bits = 8'h04;
    tick();
    chk("post_rst_state", 32'(fb_if.state_dbg), 32'h0);
    chk("post_rst_pulses",
        32'({fb_if.cmd_done, fb_if.cmd_timeout, fb_if.cmd_abort}), 32'h0);
    tick(6);
    chk("post_rst_idle", 32'(fb_if.cmd_busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
